// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_arbiter
// Purpose  : Shares a 4-digit 7-segment display between a value source, a
//            timed banner and a timed alert, then scans the digits itself.
//            Optional alert blink is enabled by defining SEG_ALERT_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_arbiter #(
   parameter int HOLD_CYCLES  = 50_000_000,
   parameter int SCAN_CYCLES  = 50_000,
   parameter int BLINK_CYCLES = 12_500_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alert_req,
   input  logic [27:0] alert_glyphs,
   input  logic        banner_req,
   input  logic [27:0] banner_glyphs,
   input  logic        value_valid,
   input  logic [27:0] value_glyphs,
   output logic [2:0]  grant,
   output logic        banner_done,
   output logic        alert_done,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int c_SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
   localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [c_SCAN_W-1:0] c_SCAN_ONE  = c_SCAN_W'(1);

   if (HOLD_CYCLES < 2 || SCAN_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_params
      $error("seg_display_arbiter: need HOLD_CYCLES>=2, SCAN_CYCLES>=1, BLINK_CYCLES>=1");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_VALUE  = 2'd1,
      S_BANNER = 2'd2,
      S_ALERT  = 2'd3
   } state_t;

   function automatic logic [2:0] f_grant(input state_t s);
      case (s)
         S_VALUE:  return 3'b001;
         S_BANNER: return 3'b010;
         S_ALERT:  return 3'b100;
         default:  return 3'b000;
      endcase
   endfunction

   state_t                r_state;
   logic [2:0]            r_grant;
   logic [c_HOLD_W-1:0]   r_timer;
   logic                  r_alert_pend;
   logic                  r_banner_pend;
   logic [27:0]           r_alert_sh;
   logic [27:0]           r_banner_sh;
   logic                  r_banner_done;
   logic                  r_alert_done;
   logic [c_SCAN_W-1:0]   r_scan_cnt;
   logic [1:0]            r_idx;
   logic [3:0]            r_an;
   logic [6:0]            r_seg;

   logic                  w_hold_last;
   logic                  w_alert_restart;
   logic                  w_banner_restart;
   state_t                w_bg_state;
   logic [27:0]           w_glyphs;
   logic [6:0]            w_digit;
   logic                  w_blank_alert;
   logic                  w_blank;

   // A re-request by the owner (or a request latched on the entry edge) restarts the hold in place.
   assign w_hold_last      = (r_timer == c_HOLD_LAST);
   assign w_alert_restart  = (r_state == S_ALERT) && (alert_req || r_alert_pend);
   assign w_banner_restart = (r_state == S_BANNER) && !r_alert_pend && (banner_req || r_banner_pend);
   assign w_bg_state       = value_valid ? S_VALUE : S_IDLE;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_grant       <= 3'b000;
         r_timer       <= '0;
         r_alert_pend  <= 1'b0;
         r_banner_pend <= 1'b0;
         r_alert_sh    <= '0;
         r_banner_sh   <= '0;
         r_banner_done <= 1'b0;
         r_alert_done  <= 1'b0;
      end else begin
         r_banner_done <= 1'b0;
         r_alert_done  <= 1'b0;
         if (alert_req) begin
            r_alert_sh <= alert_glyphs;
         end
         if (banner_req) begin
            r_banner_sh <= banner_glyphs;
         end

         case (r_state)
            S_ALERT: begin
               if (w_alert_restart) begin
                  r_timer      <= '0;
                  r_alert_pend <= 1'b0;
               end else if (w_hold_last) begin
                  r_alert_done <= 1'b1;
                  r_timer      <= '0;
                  if (r_banner_pend) begin
                     r_state       <= S_BANNER;
                     r_grant       <= f_grant(S_BANNER);
                     r_banner_pend <= 1'b0;
                  end else begin
                     r_state <= w_bg_state;
                     r_grant <= f_grant(w_bg_state);
                  end
               end else begin
                  r_timer <= r_timer + c_HOLD_ONE;
               end
            end

            S_BANNER: begin
               if (r_alert_pend) begin
                  // Preempted banner is dropped, not resumed.
                  r_state       <= S_ALERT;
                  r_grant       <= f_grant(S_ALERT);
                  r_timer       <= '0;
                  r_alert_pend  <= 1'b0;
                  r_banner_done <= 1'b1;
               end else if (w_banner_restart) begin
                  r_timer       <= '0;
                  r_banner_pend <= 1'b0;
               end else if (w_hold_last) begin
                  r_banner_done <= 1'b1;
                  r_timer       <= '0;
                  r_state       <= w_bg_state;
                  r_grant       <= f_grant(w_bg_state);
               end else begin
                  r_timer <= r_timer + c_HOLD_ONE;
               end
            end

            default: begin
               r_timer <= '0;
               if (r_alert_pend) begin
                  r_state      <= S_ALERT;
                  r_grant      <= f_grant(S_ALERT);
                  r_alert_pend <= 1'b0;
               end else if (r_banner_pend) begin
                  r_state       <= S_BANNER;
                  r_grant       <= f_grant(S_BANNER);
                  r_banner_pend <= 1'b0;
               end else begin
                  r_state <= w_bg_state;
                  r_grant <= f_grant(w_bg_state);
               end
            end
         endcase

         if (alert_req && !w_alert_restart) begin
            r_alert_pend <= 1'b1;
         end
         if (banner_req && !w_banner_restart) begin
            r_banner_pend <= 1'b1;
         end
      end
   end

`ifdef SEG_ALERT_BLINK_EN
   localparam int c_BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_CYCLES - 1);
   localparam logic [c_BLINK_W-1:0] c_BLINK_ONE  = c_BLINK_W'(1);

   logic [c_BLINK_W-1:0] r_blink_cnt;
   logic                 r_blink_on;

   // Held at phase-on outside ALERT so every alert entry starts visible.
   always_ff @(posedge clk) begin
      if (!rst_n || r_state != S_ALERT) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (r_blink_cnt == c_BLINK_LAST) begin
         r_blink_cnt <= '0;
         r_blink_on  <= !r_blink_on;
      end else begin
         r_blink_cnt <= r_blink_cnt + c_BLINK_ONE;
      end
   end

   assign w_blank_alert = (r_state == S_ALERT) && !r_blink_on;
`else
   assign w_blank_alert = 1'b0;
`endif

   assign w_blank = (r_state == S_IDLE) || w_blank_alert;

   always_comb begin
      w_glyphs = '0;
      case (r_state)
         S_VALUE:  w_glyphs = value_glyphs;
         S_BANNER: w_glyphs = r_banner_sh;
         S_ALERT:  w_glyphs = r_alert_sh;
         default:  w_glyphs = '0;
      endcase
   end

   always_comb begin
      w_digit = '0;
      case (r_idx)
         2'd0:    w_digit = w_glyphs[6:0];
         2'd1:    w_digit = w_glyphs[13:7];
         2'd2:    w_digit = w_glyphs[20:14];
         default: w_digit = w_glyphs[27:21];
      endcase
   end

   // Scan keeps rotating across state changes; an/seg lag index and state by one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_idx      <= 2'd0;
         r_an       <= 4'b0000;
         r_seg      <= 7'b0000000;
      end else begin
         if (r_scan_cnt == c_SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + c_SCAN_ONE;
         end
         r_an  <= w_blank ? 4'b0000 : (4'b0001 << r_idx);
         r_seg <= w_blank ? 7'b0000000 : w_digit;
      end
   end

   assign grant       = r_grant;
   assign banner_done = r_banner_done;
   assign alert_done  = r_alert_done;
   assign an          = r_an;
   assign seg         = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_arbiter
// Purpose  : Directed and random stimulus for seg_display_arbiter against a
//            cycle-level reference model of the display sharing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_arbiter;

   localparam int HOLD  = 20;
   localparam int SCAN  = 4;
   localparam int BLINK = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alert_req;
   logic [27:0] alert_glyphs;
   logic        banner_req;
   logic [27:0] banner_glyphs;
   logic        value_valid;
   logic [27:0] value_glyphs;
   logic [2:0]  grant;
   logic        banner_done;
   logic        alert_done;
   logic [3:0]  an;
   logic [6:0]  seg;

   always #5 clk = ~clk;

   seg_display_arbiter #(
      .HOLD_CYCLES  (HOLD),
      .SCAN_CYCLES  (SCAN),
      .BLINK_CYCLES (BLINK)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alert_req     (alert_req),
      .alert_glyphs  (alert_glyphs),
      .banner_req    (banner_req),
      .banner_glyphs (banner_glyphs),
      .value_valid   (value_valid),
      .value_glyphs  (value_glyphs),
      .grant         (grant),
      .banner_done   (banner_done),
      .alert_done    (alert_done),
      .an            (an),
      .seg           (seg)
   );

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: source 0=none 1=value 2=banner 3=alert.
   int          m_src   = 0;
   int          m_age   = 0;
   int          m_since = 0;
   int          m_idx   = 0;
   int          m_scnt  = 0;
   logic        m_pa    = 1'b0;
   logic        m_pb    = 1'b0;
   logic        m_bd    = 1'b0;
   logic        m_ad    = 1'b0;
   logic [27:0] m_sa    = '0;
   logic [27:0] m_sb    = '0;
   logic [2:0]  m_grant = '0;
   logic [3:0]  m_an    = '0;
   logic [6:0]  m_seg   = '0;

   function automatic logic [2:0] src_grant(input int s);
      return (s == 3) ? 3'b100 : (s == 2) ? 3'b010 : (s == 1) ? 3'b001 : 3'b000;
   endfunction

   task automatic model_step();
      logic [27:0] g;
      bit          blank;
      bit          ra;
      bit          rb;
      int          nxt;
      int          bg;
      if (rst_n !== 1'b1) begin
         m_src = 0; m_age = 0; m_since = 0; m_idx = 0; m_scnt = 0;
         m_pa = 1'b0; m_pb = 1'b0; m_bd = 1'b0; m_ad = 1'b0;
         m_sa = '0; m_sb = '0; m_grant = '0; m_an = '0; m_seg = '0;
         return;
      end
      g = (m_src == 1) ? value_glyphs : (m_src == 2) ? m_sb : (m_src == 3) ? m_sa : 28'h0;
      blank = (m_src == 0);
`ifdef SEG_ALERT_BLINK_EN
      if (m_src == 3 && ((m_since / BLINK) % 2) == 1) blank = 1'b1;
`endif
      m_an  = blank ? 4'b0 : 4'(1 << m_idx);
      m_seg = blank ? 7'b0 : g[m_idx*7 +: 7];
      m_scnt++;
      if (m_scnt == SCAN) begin
         m_scnt = 0;
         m_idx  = (m_idx + 1) % 4;
      end

      bg = value_valid ? 1 : 0;
      ra = (m_src == 3) && (alert_req || m_pa);
      rb = (m_src == 2) && !m_pa && (banner_req || m_pb);
      nxt = m_src;
      m_bd = 1'b0;
      m_ad = 1'b0;
      if (m_src == 3) begin
         if (!ra && m_age == HOLD - 1) begin
            m_ad = 1'b1;
            nxt  = m_pb ? 2 : bg;
         end
      end else if (m_src == 2) begin
         if (m_pa) begin
            m_bd = 1'b1;
            nxt  = 3;
         end else if (!rb && m_age == HOLD - 1) begin
            m_bd = 1'b1;
            nxt  = bg;
         end
      end else begin
         nxt = m_pa ? 3 : m_pb ? 2 : bg;
      end
      if (ra || (nxt == 3 && m_src != 3)) m_pa = 1'b0;
      if (rb || (nxt == 2 && m_src != 2)) m_pb = 1'b0;
      if (alert_req && !ra) m_pa = 1'b1;
      if (banner_req && !rb) m_pb = 1'b1;
      m_age   = (nxt != m_src || ra || rb) ? 0 : m_age + 1;
      m_since = (nxt == 3 && m_src != 3) ? 0 : m_since + 1;
      if (alert_req)  m_sa = alert_glyphs;
      if (banner_req) m_sb = banner_glyphs;
      m_src   = nxt;
      m_grant = src_grant(nxt);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("grant", 32'(grant), 32'(m_grant));
      check("banner_done", 32'(banner_done), 32'(m_bd));
      check("alert_done", 32'(alert_done), 32'(m_ad));
      check("an", 32'(an), 32'(m_an));
      check("seg", 32'(seg), 32'(m_seg));
   endtask

   task automatic wait_grant(input string tag, input logic [2:0] g);
      int k;
      k = 0;
      while (grant !== g && k < 10) begin
         tick();
         k++;
      end
      check(tag, 32'(grant), 32'(g));
   endtask

   task automatic run_grant(input logic [2:0] g, output int n, output int dones);
      n = 0;
      dones = 0;
      while (grant === g && n < 200) begin
         n++;
         if (n > 1 && (banner_done || alert_done)) dones++;
         tick();
      end
   endtask

   function automatic int an_index(input logic [3:0] a);
      case (a)
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         default: return 0;
      endcase
   endfunction

   initial begin
      int          n;
      int          d;
      int          k;
      logic [27:0] g2;

      rst_n = 1'b0; alert_req = 1'b0; banner_req = 1'b0; value_valid = 1'b0;
      alert_glyphs = '0; banner_glyphs = '0; value_glyphs = '0;
      tick();
      tick();
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_an", 32'(an), 32'h0);
      check("rst_seg", 32'(seg), 32'h0);

      // Value display and digit scan.
      rst_n = 1'b1;
      value_valid = 1'b1;
      value_glyphs = {7'h00, 7'h3F, 7'h06, 7'h5B};
      tick();
      check("t1_grant", 32'(grant), 32'h1);
      k = 0;
      while (an !== 4'b0010 && k < 20) begin
         tick();
         k++;
      end
      check("t1_an1", 32'(an), 32'h2);
      check("t1_seg1", 32'(seg), 32'h06);
      repeat (SCAN) tick();
      check("t1_an2", 32'(an), 32'h4);
      check("t1_seg2", 32'(seg), 32'h3F);
      repeat (SCAN) tick();
      check("t1_an3", 32'(an), 32'h8);
      check("t1_seg3", 32'(seg), 32'h00);
      repeat (SCAN) tick();
      check("t1_an0", 32'(an), 32'h1);
      check("t1_seg0", 32'(seg), 32'h5B);

      // Banner over value.
      banner_glyphs = 28'($urandom);
      banner_req = 1'b1;
      tick();
      banner_req = 1'b0;
      wait_grant("t2_enter", 3'b010);
      run_grant(3'b010, n, d);
      check("t2_len", 32'(n), 32'd20);
      check("t2_done", 32'(banner_done), 32'h1);
      check("t2_back", 32'(grant), 32'h1);
      check("t2_early_done", 32'(d), 32'd0);

      // Alert preempts banner in its 7th cycle.
      banner_glyphs = 28'($urandom);
      banner_req = 1'b1;
      tick();
      banner_req = 1'b0;
      wait_grant("t3_enter", 3'b010);
      repeat (6) tick();
      alert_glyphs = 28'($urandom);
      alert_req = 1'b1;
      tick();
      alert_req = 1'b0;
      check("t3_still_banner", 32'(grant), 32'h2);
      tick();
      check("t3_preempt", 32'(grant), 32'h4);
      check("t3_bdone", 32'(banner_done), 32'h1);
      run_grant(3'b100, n, d);
      check("t3_len", 32'(n), 32'd20);
      check("t3_adone", 32'(alert_done), 32'h1);
      check("t3_back", 32'(grant), 32'h1);

      // Simultaneous requests with no background value.
      value_valid = 1'b0;
      tick();
      check("t4_idle", 32'(grant), 32'h0);
      alert_glyphs = 28'($urandom);
      banner_glyphs = 28'($urandom);
      alert_req = 1'b1;
      banner_req = 1'b1;
      tick();
      alert_req = 1'b0;
      banner_req = 1'b0;
      wait_grant("t4_alert", 3'b100);
      run_grant(3'b100, n, d);
      check("t4_alen", 32'(n), 32'd20);
      check("t4_adone", 32'(alert_done), 32'h1);
      check("t4_banner", 32'(grant), 32'h2);
      run_grant(3'b010, n, d);
      check("t4_blen", 32'(n), 32'd20);
      check("t4_bdone", 32'(banner_done), 32'h1);
      check("t4_end", 32'(grant), 32'h0);
      tick();
      check("t4_an", 32'(an), 32'h0);
      check("t4_seg", 32'(seg), 32'h0);

      // Banner re-request in its 15th cycle extends the hold.
      banner_glyphs = 28'($urandom);
      banner_req = 1'b1;
      tick();
      banner_req = 1'b0;
      wait_grant("t5_enter", 3'b010);
      repeat (14) tick();
      g2 = 28'($urandom);
      banner_glyphs = g2;
      banner_req = 1'b1;
      tick();
      banner_req = 1'b0;
      tick();
      k = an_index(an);
      check("t5_newglyph", 32'(seg), 32'(g2[k*7 +: 7]));
      run_grant(3'b010, n, d);
      check("t5_len", 32'(16 + n), 32'd35);
      check("t5_no_done", 32'(d), 32'd0);

      // Reset in the middle of an alert.
      alert_glyphs = 28'($urandom);
      alert_req = 1'b1;
      tick();
      alert_req = 1'b0;
      wait_grant("t6_enter", 3'b100);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      check("t6_grant", 32'(grant), 32'h0);
      check("t6_an", 32'(an), 32'h0);
      check("t6_seg", 32'(seg), 32'h0);
      check("t6_adone", 32'(alert_done), 32'h0);
      rst_n = 1'b1;
      tick();
      tick();
      check("t6_lost", 32'(grant), 32'h0);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         alert_req     = ($urandom_range(0, 39) == 0);
         banner_req    = ($urandom_range(0, 39) == 0);
         alert_glyphs  = 28'($urandom);
         banner_glyphs = 28'($urandom);
         if ($urandom_range(0, 49) == 0) value_valid = ~value_valid;
         if ($urandom_range(0, 9) == 0) value_glyphs = 28'($urandom);
         rst_n = ($urandom_range(0, 599) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
